// File: rtl/core_defs.sv
// rtl/core_defs.sv - shared core definitions: fetch FSM encoding, bubble instruction, IF/ID entry
package core_defs;

   localparam int          XLEN     = 32;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic            valid;
      logic            fault;
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc4;
   } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, hold and bubble controls
module if_id_reg
   import core_defs::*;
#(
   parameter logic [XLEN-1:0] BUBBLE_INST = NOP_INST
) (
   input  logic   clk,
   input  logic   nrst,
   input  logic   i_load,
   input  logic   i_bubble,
   input  if_id_t i_entry,
   output if_id_t o_entry
);

   if_id_t r_entry;

   // A bubble keeps pc/pc4 so the last fetched address stays visible downstream.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_entry.valid <= 1'b0;
         r_entry.fault <= 1'b0;
         r_entry.inst  <= BUBBLE_INST;
         r_entry.pc    <= '0;
         r_entry.pc4   <= '0;
      end else if (i_bubble) begin
         r_entry.valid <= 1'b0;
         r_entry.fault <= 1'b0;
         r_entry.inst  <= BUBBLE_INST;
      end else if (i_load) begin
         r_entry <= i_entry;
      end
   end

   assign o_entry = r_entry;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32 IF stage: PC, next-PC selection, fetch fault check, BOOT/RUN/HALTED FSM
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          ADDR_WID   = 30,
   parameter int          PROG_DEPTH = 512,
   parameter logic [31:0] NOP_INST   = core_defs::NOP_INST
) (
   input  logic                      clk,
   input  logic                      nrst,
   input  logic                      stall,
   input  logic                      redirect_valid,
   input  logic [core_defs::XLEN-1:0] redirect_pc,
   input  logic                      halt_req,
   output logic [ADDR_WID-1:0]       imem_addr,
   input  logic [core_defs::XLEN-1:0] imem_rdata,
   output logic                      id_valid,
   output logic [core_defs::XLEN-1:0] id_inst,
   output logic [core_defs::XLEN-1:0] id_pc,
   output logic [core_defs::XLEN-1:0] id_pc4,
   output logic                      id_fault,
   output logic                      halted
);

   core_defs::fetch_state_t r_state;
   logic [31:0]             r_pc;
   logic                    r_halted;

   logic [31:0]       w_pc4;
   logic              w_fault;
   logic              w_load;
   logic              w_bubble;
   core_defs::if_id_t w_entry;
   core_defs::if_id_t w_id;

   assign w_pc4     = r_pc + 32'd4;
   assign imem_addr = r_pc[ADDR_WID+1:2];

   // Bound check on the full word index so high PC bits cannot alias into range.
   assign w_fault = (r_pc[1:0] != 2'b00) || ({2'b00, r_pc[31:2]} >= 32'(PROG_DEPTH));

   always_comb begin
      w_load         = 1'b0;
      w_bubble       = 1'b0;
      w_entry.valid  = 1'b1;
      w_entry.fault  = 1'b0;
      w_entry.inst   = imem_rdata;
      w_entry.pc     = r_pc;
      w_entry.pc4    = w_pc4;
      case (r_state)
         core_defs::ST_RUN: begin
            if (redirect_valid || halt_req) begin
               w_bubble = 1'b1;
            end else if (!stall) begin
               w_load = 1'b1;
               if (w_fault) begin
                  w_entry.fault = 1'b1;
                  w_entry.inst  = NOP_INST;
               end
            end
         end
         default: w_bubble = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state  <= core_defs::ST_BOOT;
         r_pc     <= RESET_PC;
         r_halted <= 1'b0;
      end else begin
         case (r_state)
            core_defs::ST_BOOT: begin
               r_state <= core_defs::ST_RUN;
            end
            core_defs::ST_RUN: begin
               if (redirect_valid) begin
                  r_pc <= redirect_pc;
               end else if (halt_req) begin
                  r_state  <= core_defs::ST_HALTED;
                  r_halted <= 1'b1;
               end else if (!stall) begin
                  if (w_fault) begin
                     r_state  <= core_defs::ST_HALTED;
                     r_halted <= 1'b1;
                  end else begin
                     r_pc <= w_pc4;
                  end
               end
            end
            core_defs::ST_HALTED: begin
               if (redirect_valid) begin
                  r_pc     <= redirect_pc;
                  r_state  <= core_defs::ST_RUN;
                  r_halted <= 1'b0;
               end
            end
            default: begin
               r_state  <= core_defs::ST_BOOT;
               r_halted <= 1'b0;
            end
         endcase
      end
   end

   if_id_reg #(
      .BUBBLE_INST(NOP_INST)
   ) u_if_id (
      .clk      (clk),
      .nrst     (nrst),
      .i_load   (w_load),
      .i_bubble (w_bubble),
      .i_entry  (w_entry),
      .o_entry  (w_id)
   );

   assign id_valid = w_id.valid;
   assign id_fault = w_id.fault;
   assign id_inst  = w_id.inst;
   assign id_pc    = w_id.pc;
   assign id_pc4   = w_id.pc4;
   assign halted   = r_halted;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with directed vectors
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] IA  = 32'hA1A1_0001;
   localparam logic [31:0] IB  = 32'hB2B2_0002;
   localparam logic [31:0] IC  = 32'hC3C3_0003;
   localparam logic [31:0] ID  = 32'hD4D4_0004;

   typedef struct packed {
      logic [63:0] tag;
      logic        v;
      logic        f;
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        h;
      logic [29:0] addr;
   } exp_t;

   logic        clk = 1'b0;
   logic        nrst;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt_req;
   logic [29:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic [31:0] id_pc4;
   logic        id_fault;
   logic        halted;

   logic [31:0] mem [0:511];
   exp_t        q[$];
   logic        done = 1'b0;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

   always #5 clk = ~clk;

   assign imem_rdata = (imem_addr < 30'd512) ? mem[imem_addr[8:0]] : 32'hDEAD_BEEF;

   fetch_stage dut (
      .clk            (clk),
      .nrst           (nrst),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .id_valid       (id_valid),
      .id_inst        (id_inst),
      .id_pc          (id_pc),
      .id_pc4         (id_pc4),
      .id_fault       (id_fault),
      .halted         (halted)
   );

   task automatic expect_now(input logic [63:0] tag, input logic v, input logic f,
                             input logic [31:0] inst, input logic [31:0] pc,
                             input logic [31:0] pc4, input logic h, input logic [29:0] addr);
      exp_t e;
      e.tag = tag; e.v = v; e.f = f; e.inst = inst;
      e.pc = pc; e.pc4 = pc4; e.h = h; e.addr = addr;
      q.push_back(e);
   endtask

   // Drive one cycle of inputs; the expectation describes the DUT after that edge.
   task automatic step(input logic s, input logic rv, input logic [31:0] rpc, input logic hr,
                       input logic [63:0] tag, input logic v, input logic f,
                       input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] pc4, input logic h, input logic [29:0] addr);
      stall          = s;
      redirect_valid = rv;
      redirect_pc    = rpc;
      halt_req       = hr;
      @(posedge clk);
      expect_now(tag, v, f, inst, pc, pc4, h, addr);
      #1;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      halt_req       = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      cyc = cyc + 1;
      if (q.size() > 0) begin
         e = q.pop_front();
         checks = checks + 1;
         if ({id_valid, id_fault, id_inst, id_pc, id_pc4, halted, imem_addr} !==
             {e.v, e.f, e.inst, e.pc, e.pc4, e.h, e.addr}) begin
            errors = errors + 1;
            $display("FAIL %s: got v=%b f=%b inst=%h pc=%h pc4=%h halted=%b addr=%h, want v=%b f=%b inst=%h pc=%h pc4=%h halted=%b addr=%h",
                     e.tag, id_valid, id_fault, id_inst, id_pc, id_pc4, halted, imem_addr,
                     e.v, e.f, e.inst, e.pc, e.pc4, e.h, e.addr);
         end
      end
      if (done) begin
         checks = checks + 1;
         if (q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
         end
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $finish;
      end else if (cyc > 5000) begin
         errors = errors + 1;
         $display("FAIL timeout: cycle %0d reached, want done before 5000", cyc);
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $finish;
      end
   end

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 32'h0100_0000 | 32'(i);
      mem[0] = IA; mem[1] = IB; mem[2] = IC; mem[3] = ID;
      nrst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; halt_req = 1'b0;
      #1;
      expect_now("rst0", 0, 0, NOP, 32'h0, 32'h0, 0, 30'h0);
      @(negedge clk); #1 nrst = 1'b1;

      // reset release, BOOT ignores redirect, then stream
      step(0, 1, 32'h100, 0, "bootrdr", 0, 0, NOP, 32'h0, 32'h0, 0, 30'h0);
      step(0, 0, 0, 0, "A",  1, 0, IA, 32'h0, 32'h4,  0, 30'h1);
      step(0, 0, 0, 0, "B",  1, 0, IB, 32'h4, 32'h8,  0, 30'h2);
      step(0, 0, 0, 0, "C",  1, 0, IC, 32'h8, 32'hC,  0, 30'h3);
      step(0, 0, 0, 0, "D",  1, 0, ID, 32'hC, 32'h10, 0, 30'h4);

      // stall holding B
      step(0, 1, 32'h0, 0, "rdr0", 0, 0, NOP, 32'hC, 32'h10, 0, 30'h0);
      step(0, 0, 0, 0, "A1", 1, 0, IA, 32'h0, 32'h4, 0, 30'h1);
      step(0, 0, 0, 0, "B1", 1, 0, IB, 32'h4, 32'h8, 0, 30'h2);
      for (int i = 0; i < 3; i++)
         step(1, 0, 0, 0, "stall", 1, 0, IB, 32'h4, 32'h8, 0, 30'h2);
      step(0, 0, 0, 0, "C1", 1, 0, IC, 32'h8, 32'hC, 0, 30'h3);

      // redirect overrides stall
      step(1, 1, 32'h100, 0, "rdrstl", 0, 0, NOP, 32'h8, 32'hC, 0, 30'h40);
      step(0, 0, 0, 0, "m64", 1, 0, 32'h0100_0040, 32'h100, 32'h104, 0, 30'h41);

      // misaligned, out-of-range, last word, wrap
      step(0, 1, 32'h802, 0, "rdr802", 0, 0, NOP, 32'h100, 32'h104, 0, 30'h200);
      step(0, 0, 0, 0, "misal",  1, 1, NOP, 32'h802, 32'h806, 1, 30'h200);
      step(0, 0, 0, 0, "hltbub", 0, 0, NOP, 32'h802, 32'h806, 1, 30'h200);
      step(1, 0, 0, 0, "hltstl", 0, 0, NOP, 32'h802, 32'h806, 1, 30'h200);
      step(0, 1, 32'h800, 0, "rdr800", 0, 0, NOP, 32'h802, 32'h806, 0, 30'h200);
      step(0, 0, 0, 0, "oor",    1, 1, NOP, 32'h800, 32'h804, 1, 30'h200);
      step(0, 1, 32'h7FC, 0, "rdr7fc", 0, 0, NOP, 32'h800, 32'h804, 0, 30'h1FF);
      step(0, 0, 0, 0, "last",   1, 0, 32'h0100_01FF, 32'h7FC, 32'h800, 0, 30'h200);
      step(0, 0, 0, 0, "oor2",   1, 1, NOP, 32'h800, 32'h804, 1, 30'h200);
      step(0, 1, 32'hFFFF_FFFC, 0, "rdrwrap", 0, 0, NOP, 32'h800, 32'h804, 0, 30'h3FFF_FFFF);
      step(0, 0, 0, 0, "wrap",   1, 1, NOP, 32'hFFFF_FFFC, 32'h0, 1, 30'h3FFF_FFFF);

      // halt (wins over stall) and resume
      step(0, 1, 32'h10, 0, "rdr10", 0, 0, NOP, 32'hFFFF_FFFC, 32'h0, 0, 30'h4);
      step(0, 0, 0, 0, "m4",     1, 0, 32'h0100_0004, 32'h10, 32'h14, 0, 30'h5);
      step(1, 0, 0, 1, "halt",   0, 0, NOP, 32'h10, 32'h14, 1, 30'h5);
      step(0, 0, 0, 0, "hold",   0, 0, NOP, 32'h10, 32'h14, 1, 30'h5);
      step(0, 1, 32'h20, 0, "rdr20", 0, 0, NOP, 32'h10, 32'h14, 0, 30'h8);
      step(0, 0, 0, 0, "m8",     1, 0, 32'h0100_0008, 32'h20, 32'h24, 0, 30'h9);

      // asynchronous reset mid-run at pc=0x40
      step(0, 1, 32'h40, 0, "rdr40", 0, 0, NOP, 32'h20, 32'h24, 0, 30'h10);
      @(negedge clk); #1 nrst = 1'b0;
      expect_now("rst1", 0, 0, NOP, 32'h0, 32'h0, 0, 30'h0);
      @(negedge clk); #1 nrst = 1'b1;
      step(0, 0, 0, 0, "boot2", 0, 0, NOP, 32'h0, 32'h0, 0, 30'h0);
      step(0, 0, 0, 0, "A2",    1, 0, IA, 32'h0, 32'h4, 0, 30'h1);

      @(negedge clk);
      @(negedge clk);
      #1 done = 1'b1;
   end

endmodule
